level_generator: RTL and testbench

- Upstream producer of the level consumed by game_core: drives level_data and level_length, which feed the playback and response shifters.
- On new_game it fills a random sequence of one-hot notes from a free-running LFSR, then exposes a growing prefix (Simon-style).
- level_length increments on each level_won; after the last level it flags game_complete.

---
 rtl/level_generator.sv | 102 ++++++++++
 tb/tb_level_generator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/level_generator.sv
// Simon-style level source: fills a random one-hot note sequence from a free-running
// LFSR on new_game, then exposes a prefix that grows by one note per level_won.
module level_generator #(
  parameter int          MAX_NOTES = 4,
  parameter int          START_LEN = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   level_won,
  output logic [4*MAX_NOTES-1:0] level_data,
  output logic [3:0]             level_length,
  output logic                   level_valid,
  output logic                   game_complete
);

  localparam logic [3:0]  LAST_SLOT   = 4'(MAX_NOTES - 1);
  localparam logic [3:0]  MAX_LEN     = 4'(MAX_NOTES);
  localparam logic [3:0]  START_LEN_L = 4'(START_LEN);
  localparam logic [15:0] LFSR_MASK   = 16'hB400;

  typedef enum logic [1:0] {IDLE, GEN, READY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [3:0]  slot;
  logic [3:0]  note;

  // Galois right-shift step; a nonzero seed never reaches the all-zero state
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [3:0] note_of(input logic [1:0] idx);
    note_of = 4'b0001 << idx;
  endfunction

  assign note = note_of(lfsr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = GEN;
    end else begin
      case (state)
        GEN:     if (slot == LAST_SLOT) state_nxt = READY;
        READY:   if (level_won && (level_length == MAX_LEN)) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr          <= SEED;
      slot          <= 4'd0;
      level_data    <= '0;
      level_length  <= 4'd0;
      level_valid   <= 1'b0;
      game_complete <= 1'b0;
    end else begin
      // The LFSR runs in every state so new_game timing picks the sequence
      lfsr <= lfsr_step(lfsr);
      if (new_game) begin
        slot          <= 4'd0;
        level_data    <= '0;
        level_length  <= START_LEN_L;
        level_valid   <= 1'b0;
        game_complete <= 1'b0;
      end else begin
        case (state)
          GEN: begin
            for (int k = 0; k < MAX_NOTES; k++) begin
              if (slot == 4'(k)) level_data[4*MAX_NOTES-1-4*k -: 4] <= note;
            end
            slot <= slot + 4'd1;
            if (slot == LAST_SLOT) level_valid <= 1'b1;
          end
          READY: begin
            if (level_won) begin
              if (level_length < MAX_LEN) begin
                level_length <= level_length + 4'd1;
              end else begin
                level_valid   <= 1'b0;
                game_complete <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator: generation latency, progression, priority,
// abort and restart against a reference LFSR seeded 16'hACE1.
module tb_level_generator;

  localparam int MAX_NOTES = 4;
  localparam int W         = 4 * MAX_NOTES;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         new_game  = 1'b0;
  logic         level_won = 1'b0;
  logic [W-1:0] level_data;
  logic [3:0]   level_length;
  logic         level_valid;
  logic         game_complete;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  level_generator #(
    .MAX_NOTES(MAX_NOTES),
    .START_LEN(1),
    .SEED     (16'hACE1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .level_won    (level_won),
    .level_data   (level_data),
    .level_length (level_length),
    .level_valid  (level_valid),
    .game_complete(game_complete)
  );

  function automatic logic [15:0] adv(input logic [15:0] v);
    adv = {1'b0, v[15:1]};
    if (v[0]) adv = adv ^ 16'hB400;
  endfunction

  // Notes written at the four GEN edges, given the LFSR value right after the new_game edge
  function automatic logic [W-1:0] exp_notes(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    exp_notes = '0;
    for (int k = 0; k < MAX_NOTES; k++) begin
      exp_notes[W-1-4*k -: 4] = 4'b0001 << v[1:0];
      v = adv(v);
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= adv(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_data"},     64'(level_data),    64'd0);
    check_eq({tag, "_length"},   64'(level_length),  64'd0);
    check_eq({tag, "_valid"},    64'(level_valid),   64'd0);
    check_eq({tag, "_complete"}, 64'(game_complete), 64'd0);
  endtask

  // One-cycle new_game (optionally with level_won held through GEN), then latency checks
  task automatic start_gen(input logic won_in, input string tag, output logic [W-1:0] exp);
    new_game  = 1'b1;
    level_won = won_in;
    @(negedge clk);
    new_game = 1'b0;
    exp = exp_notes(m_lfsr);
    check_eq({tag, "_valid_t0"},  64'(level_valid),  64'd0);
    check_eq({tag, "_length_t0"}, 64'(level_length), 64'd1);
    for (int i = 1; i < MAX_NOTES; i++) begin
      @(negedge clk);
      check_eq({tag, "_valid_lat"}, 64'(level_valid), 64'd0);
    end
    @(negedge clk);
    level_won = 1'b0;
    check_eq({tag, "_valid_up"}, 64'(level_valid),  64'd1);
    check_eq({tag, "_length"},   64'(level_length), 64'd1);
    check_eq({tag, "_data"},     64'(level_data),   64'(exp));
    for (int k = 0; k < MAX_NOTES; k++)
      check_eq({tag, "_onehot"}, 64'($onehot(level_data[W-1-4*k -: 4])), 64'd1);
  endtask

  task automatic pulse_won();
    level_won = 1'b1;
    @(negedge clk);
    level_won = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d0, d1, d2, d3, pulse_exp, rexp;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_zero("idle");

    start_gen(1'b0, "gen1", d0);

    for (int i = 0; i < 3; i++) begin
      pulse_won();
      check_eq("prog_length", 64'(level_length), 64'(i + 2));
      check_eq("prog_data",   64'(level_data),   64'(d0));
      check_eq("prog_valid",  64'(level_valid),  64'd1);
    end
    pulse_won();
    check_eq("final_complete", 64'(game_complete), 64'd1);
    check_eq("final_valid",    64'(level_valid),   64'd0);
    check_eq("final_length",   64'(level_length),  64'd4);
    check_eq("final_data",     64'(level_data),    64'(d0));
    pulse_won();
    check_eq("done_complete", 64'(game_complete), 64'd1);
    check_eq("done_valid",    64'(level_valid),   64'd0);
    check_eq("done_length",   64'(level_length),  64'd4);
    check_eq("done_data",     64'(level_data),    64'(d0));

    // Asynchronous reset from DONE, sampled before any clock edge
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_zero("post_rst");

    start_gen(1'b0, "prio_setup", d1);
    pulse_won();
    pulse_won();
    check_eq("prio_len3", 64'(level_length), 64'd3);
    start_gen(1'b1, "prio", d2);

    // Abort two cycles into GEN
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    d3 = exp_notes(m_lfsr);
    repeat (2) @(negedge clk);
    check_eq("abort_partial", 64'(level_data[W-1 -: 8]), 64'(d3[W-1 -: 8]));
    #2 reset = 1'b1;
    #1 check_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    start_gen(1'b0, "regen", d3);

    // Pick a start point where a 1-cycle pulse and a 3-cycle hold give different notes
    for (int i = 0; i < 20; i++) begin
      if (exp_notes(adv(m_lfsr)) != exp_notes(adv(adv(adv(m_lfsr))))) break;
      @(negedge clk);
    end
    pulse_exp = exp_notes(adv(m_lfsr));
    new_game = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(level_valid), 64'd0);
    end
    new_game = 1'b0;
    rexp = exp_notes(m_lfsr);
    for (int i = 1; i < MAX_NOTES; i++) begin
      @(negedge clk);
      check_eq("restart_valid_lat", 64'(level_valid), 64'd0);
    end
    @(negedge clk);
    check_eq("restart_valid_up", 64'(level_valid), 64'd1);
    check_eq("restart_data",     64'(level_data),  64'(rexp));
    check_eq("restart_differs",  64'(level_data != pulse_exp), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
